// File: rtl/range_packet_framer_if.sv
// ============================================================================
// Module : range_packet_framer_if
// Brief  : Sample-stream input and range-finder output bundle for the framer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface range_packet_framer_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_go;
  logic             out_finish;
  logic             pkt_drop;
  logic             frame_err;
  logic             busy;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready, out_data, out_go, out_finish, pkt_drop, frame_err, busy
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready, out_data, out_go, out_finish, pkt_drop, frame_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/range_packet_framer.sv
// ============================================================================
// Module : range_packet_framer
// Brief  : Buffers whole sop/eop packets and replays them contiguously with
//          go/finish markers; malformed or oversize packets are dropped.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_packet_framer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int GAP   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  range_packet_framer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LW-1:0]    r_len, w_len_nxt;
  logic [LW-1:0]    r_rd_ptr, w_rd_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic             r_in_pkt, w_in_pkt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_pkt_drop, w_pkt_drop_nxt;
  logic             w_wr_en;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_buf [DEPTH];

  // Reset gates ready combinationally so no beat is taken while reset is held.
  assign w_in_ready = (r_state == ST_COLLECT) && !reset;
  assign w_accept   = bus.in_valid && w_in_ready;

  // A 1-sample packet drains over two cycles so go and finish never coincide.
  assign w_last   = (r_len == LW'(1)) ? (r_rd_ptr == LW'(1))
                                      : (r_rd_ptr == r_len - LW'(1));
  assign w_rd_idx = (r_len == LW'(1)) ? '0 : r_rd_ptr[IW-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_rd_nxt        = r_rd_ptr;
    w_gap_nxt       = r_gap;
    w_in_pkt_nxt    = r_in_pkt;
    w_ovf_nxt       = r_ovf;
    w_frame_err_nxt = 1'b0;
    w_pkt_drop_nxt  = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = '0;
    unique case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          if (bus.in_sop) begin
            w_frame_err_nxt = r_in_pkt;
            w_ovf_nxt       = 1'b0;
            w_wr_en         = 1'b1;
            w_len_nxt       = LW'(1);
            w_in_pkt_nxt    = !bus.in_eop;
            if (bus.in_eop) begin
              w_state_nxt = ST_DRAIN;
              w_rd_nxt    = '0;
            end
          end else if (!r_in_pkt) begin
            w_frame_err_nxt = 1'b1;
          end else if (r_ovf || (r_len == LW'(DEPTH))) begin
            // Oversize: swallow the rest of the packet, report on eop.
            if (bus.in_eop) begin
              w_pkt_drop_nxt = 1'b1;
              w_ovf_nxt      = 1'b0;
              w_in_pkt_nxt   = 1'b0;
              w_len_nxt      = '0;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_len[IW-1:0];
            w_len_nxt = r_len + LW'(1);
            if (bus.in_eop) begin
              w_state_nxt  = ST_DRAIN;
              w_rd_nxt     = '0;
              w_in_pkt_nxt = 1'b0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (w_last) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = '0;
          w_len_nxt   = '0;
          w_rd_nxt    = '0;
        end else begin
          w_rd_nxt = r_rd_ptr + LW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == GW'(GAP - 1)) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_COLLECT;
      r_len       <= '0;
      r_rd_ptr    <= '0;
      r_gap       <= '0;
      r_in_pkt    <= 1'b0;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
      r_pkt_drop  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_gap       <= w_gap_nxt;
      r_in_pkt    <= w_in_pkt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_pkt_drop  <= w_pkt_drop_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_buf[w_wr_idx] <= bus.in_data;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_data   = (r_state == ST_DRAIN) ? r_buf[w_rd_idx] : '0;
  assign bus.out_go     = (r_state == ST_DRAIN) && (r_rd_ptr == '0);
  assign bus.out_finish = (r_state == ST_DRAIN) && w_last;
  assign bus.pkt_drop   = r_pkt_drop;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != ST_COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_range_packet_framer.sv
// ============================================================================
// Module : tb_range_packet_framer
// Brief  : Directed vector table plus hand sequences for range_packet_framer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_range_packet_framer;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d = '0;
  logic         v = 1'b0, s = 1'b0, e = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           both_cnt = 0;
  int           go4_cnt = 0;

  always #5 clock = ~clock;

  range_packet_framer_if #(.WIDTH(W)) bus16 ();
  range_packet_framer_if #(.WIDTH(W)) bus4 ();

  assign bus16.in_data  = d;
  assign bus16.in_valid = v;
  assign bus16.in_sop   = s;
  assign bus16.in_eop   = e;
  assign bus4.in_data   = d;
  assign bus4.in_valid  = v;
  assign bus4.in_sop    = s;
  assign bus4.in_eop    = e;

  range_packet_framer #(.WIDTH(W), .DEPTH(16), .GAP(1)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16.slave)
  );

  range_packet_framer #(.WIDTH(W), .DEPTH(4), .GAP(1)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4.slave)
  );

  always @(negedge clock) begin
    if ((bus16.out_go && bus16.out_finish) || (bus4.out_go && bus4.out_finish))
      both_cnt <= both_cnt + 1;
    if (bus4.out_go)
      go4_cnt <= go4_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] d;
    logic         v, s, e;
    logic [21:0]  exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [21:0] obs16();
    return {bus16.in_ready, bus16.busy, bus16.out_go, bus16.out_finish,
            bus16.frame_err, bus16.pkt_drop, bus16.out_data};
  endfunction

  function automatic logic [21:0] obs4();
    return {bus4.in_ready, bus4.busy, bus4.out_go, bus4.out_finish,
            bus4.frame_err, bus4.pkt_drop, bus4.out_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Row: inputs for a cycle and {ready,busy,go,finish,frame_err,pkt_drop,data} seen in it.
  task automatic add(input logic [W-1:0] di, input logic vi, si, ei,
                     input logic rdy, bsy, go, fin, fe, drp, input logic [W-1:0] od);
    vec_t r;
    r.d = di; r.v = vi; r.s = si; r.e = ei;
    r.exp = {rdy, bsy, go, fin, fe, drp, od};
    tbl.push_back(r);
  endtask

  task automatic add_idle(input logic rdy, bsy, go, fin, fe, drp, input logic [W-1:0] od);
    add('0, 1'b0, 1'b0, 1'b0, rdy, bsy, go, fin, fe, drp, od);
  endtask

  task automatic send(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      d = W'(base + k); v = 1'b1; s = (k == 0); e = (k == n - 1);
      @(negedge clock);
      chk("send_ready", {30'd0, bus16.in_ready, bus4.in_ready}, 32'd3);
    end
    @(posedge clock); #1;
    d = '0; v = 1'b0; s = 1'b0; e = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clock);
    while (!(bus16.in_ready && bus4.in_ready) && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("wait_idle_timeout", {31'd0, (k >= 40)}, 32'd0);
  endtask

  task automatic check_drain(input bit use4, input int base, input int n, input string nm);
    logic [18:0] act, ex;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      act = use4 ? {bus4.busy, bus4.out_go, bus4.out_finish, bus4.out_data}
                 : {bus16.busy, bus16.out_go, bus16.out_finish, bus16.out_data};
      ex  = {1'b1, (i == 0), (i == n - 1), W'(base + i)};
      chk(nm, {13'd0, act}, {13'd0, ex});
    end
    @(negedge clock);
    act = use4 ? {bus4.busy, bus4.out_go, bus4.out_finish, bus4.out_data}
               : {bus16.busy, bus16.out_go, bus16.out_finish, bus16.out_data};
    chk({nm, "_gap"}, {13'd0, act}, {13'd0, 1'b1, 18'd0});
  endtask

  initial begin
    int g0;

    // Packet 10,3,7,20,4 then replay and one gap cycle.
    add(10, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 3, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 7, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(20, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 4, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    add_idle(0, 1, 1, 0, 0, 0, 10);
    add_idle(0, 1, 0, 0, 0, 0, 3);
    add_idle(0, 1, 0, 0, 0, 0, 7);
    add_idle(0, 1, 0, 0, 0, 0, 20);
    add_idle(0, 1, 0, 1, 0, 0, 4);
    add_idle(0, 1, 0, 0, 0, 0, 0);
    // Single-beat packet 42.
    add(42, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0);
    add_idle(0, 1, 1, 0, 0, 0, 42);
    add_idle(0, 1, 0, 1, 0, 0, 42);
    add_idle(0, 1, 0, 0, 0, 0, 0);
    // Stray beat, then 1(sop),2,9(sop),5(eop).
    add( 5, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 1, 1, 1, 0,  1, 0, 0, 0, 1, 0, 0);
    add( 2, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 9, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    add( 5, 1, 0, 1,  1, 0, 0, 0, 1, 0, 0);
    add_idle(0, 1, 1, 0, 0, 0, 9);
    add_idle(0, 1, 0, 1, 0, 0, 5);
    add_idle(0, 1, 0, 0, 0, 0, 0);
    // Packet 8,_,_,1,_,6 with valid gaps replays contiguously.
    add( 8, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0, 0);
    add( 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0, 0);
    add( 6, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    add_idle(0, 1, 1, 0, 0, 0, 8);
    add_idle(0, 1, 0, 0, 0, 0, 1);
    add_idle(0, 1, 0, 1, 0, 0, 6);
    add_idle(0, 1, 0, 0, 0, 0, 0);
    add_idle(1, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    chk("reset_state16", {10'd0, obs16()}, 32'd0);
    chk("reset_state4",  {10'd0, obs4()},  32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("ready_after_release", {30'd0, bus16.in_ready, bus4.in_ready}, 32'd3);

    foreach (tbl[i]) begin
      @(posedge clock); #1;
      d = tbl[i].d; v = tbl[i].v; s = tbl[i].s; e = tbl[i].e;
      @(negedge clock);
      chk($sformatf("vec%0d", i), {10'd0, obs16()}, {10'd0, tbl[i].exp});
    end

    // Oversize packet on the DEPTH=4 instance, then a normal packet.
    wait_idle();
    g0 = go4_cnt;
    send(11, 6);
    @(negedge clock);
    chk("ovf_drop_pulse", {28'd0, bus4.pkt_drop, bus4.out_go, bus4.busy, bus4.in_ready}, 32'h9);
    @(negedge clock);
    chk("ovf_drop_end", {29'd0, bus4.pkt_drop, bus4.out_go, bus4.busy}, 32'd0);
    chk("ovf_no_go", go4_cnt - g0, 32'd0);
    wait_idle();
    send(21, 3);
    check_drain(1'b1, 21, 3, "after_ovf_fwd");

    // Reset in the second drain cycle of a 4-beat packet.
    wait_idle();
    send(31, 4);
    @(negedge clock);
    chk("rst_mid_go", {13'd0, bus16.out_go, bus16.out_finish, bus16.out_data},
        {13'd0, 1'b1, 1'b0, 16'd31});
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_async16", {10'd0, obs16()}, 32'd0);
    chk("rst_mid_async4",  {10'd0, obs4()},  32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", {30'd0, bus16.in_ready, bus4.in_ready}, 32'd3);
    send(51, 3);
    check_drain(1'b0, 51, 3, "after_rst_fwd");

    chk("no_go_finish_overlap", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
